onewire_master: RTL and testbench



---
 rtl/onewire_pkg.sv | 53 +++++
 rtl/onewire_if.sv | 31 +++
 rtl/onewire_tick.sv | 33 +++
 rtl/onewire_master.sv | 174 +++++++++++++++++
 tb/tb_onewire_master.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-wire bus master: FSM encoding, register map
// and slot timing tables (in 1 us base ticks).
// Used by onewire_master; no logic of its own.
package onewire_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_REL  = 2'd2;

    // Register addresses
    localparam logic ADDR_CTRL   = 1'b0;
    localparam logic ADDR_IRQ_EN = 1'b1;

    // CTRL/STATUS bit indices
    localparam int CTRL_DATA = 0;
    localparam int CTRL_RST  = 1;
    localparam int CTRL_PWR  = 2;
    localparam int CTRL_OVD  = 3;
    localparam int CTRL_BUSY = 4;
    localparam int CTRL_PEND = 5;

    typedef logic [9:0] tick_t;

    // Per-slot timing: end of driven-low phase, sample point, end of slot
    typedef struct packed {
        tick_t t_low;
        tick_t t_smp;
        tick_t t_end;
    } slot_timing_t;

    localparam slot_timing_t STD_RESET  = '{10'd480, 10'd550, 10'd960};
    localparam slot_timing_t STD_WRITE0 = '{10'd60,  10'd15,  10'd70};
    localparam slot_timing_t STD_WRITE1 = '{10'd6,   10'd15,  10'd70};

    localparam slot_timing_t OVD_RESET  = '{10'd48,  10'd56,  10'd96};
    localparam slot_timing_t OVD_WRITE0 = '{10'd8,   10'd2,   10'd10};
    localparam slot_timing_t OVD_WRITE1 = '{10'd1,   10'd2,   10'd10};

    // A read slot is a write-1 slot; the sample is taken either way.
    function automatic slot_timing_t std_timing(input logic rst, input logic wbit);
        if (rst)        return STD_RESET;
        else if (!wbit) return STD_WRITE0;
        else            return STD_WRITE1;
    endfunction

    function automatic slot_timing_t ovd_timing(input logic rst, input logic wbit);
        if (rst)        return OVD_RESET;
        else if (!wbit) return OVD_WRITE0;
        else            return OVD_WRITE1;
    endfunction

endpackage

// File: rtl/onewire_if.sv
// Avalon-MM slave bus of the 1-wire master (one address bit, 32-bit data).
// Zero-latency reads: readdata is combinational from address.
// No backpressure: no waitrequest, every access completes in one clock.
interface onewire_if;
    logic        avalon_address;
    logic        avalon_read;
    logic        avalon_write;
    logic [31:0] avalon_writedata;
    logic [31:0] avalon_readdata;
    logic        avalon_interrupt;

    // Peripheral side
    modport slave (
        input  avalon_address,
        input  avalon_read,
        input  avalon_write,
        input  avalon_writedata,
        output avalon_readdata,
        output avalon_interrupt
    );

    // Host side
    modport master (
        output avalon_address,
        output avalon_read,
        output avalon_write,
        output avalon_writedata,
        input  avalon_readdata,
        input  avalon_interrupt
    );
endinterface

// File: rtl/onewire_tick.sv
// Base-tick prescaler: counts 0..DIV-1 and pulses tick for one clock at DIV-1.
// Latency: first tick DIV clocks after clr drops; then one tick every DIV clocks.
// No backpressure; clr holds the count at 0.
// Ports: clk, rst_n (sync, active-low), clr (hold at zero), tick (1-clock pulse).
module onewire_tick #(
    parameter int DIV = 33
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    always_comb begin
        tick  = !clr && (pre_q == PW'(DIV - 1));
        pre_d = pre_q + PW'(1);
        if (clr || tick) begin
            pre_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
endmodule

// File: rtl/onewire_master.sv
// 1-wire bus master with Avalon-MM slave: reset/presence and single-bit slots.
// Latency: a slot takes T_END base ticks (DIV clocks each); reads are zero-latency.
// No backpressure: CTRL writes while busy (including the completion edge) are dropped.
// Ports: clk, rst_n (sync, active-low), avs (Avalon slave bus), owr_e (drive low
// enable), owr_p (strong pullup), owr_i (raw pad input, asynchronous).
// Build option: define ONEWIRE_OVERDRIVE_EN to make CTRL.OVD select overdrive timing.
module onewire_master
    import onewire_pkg::*;
#(
    parameter int DIV = 33,
    parameter int CW  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    onewire_if.slave   avs,
    output logic       owr_e,
    output logic       owr_p,
    input  logic       owr_i
);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_nxt;
    logic          wbit_q, wbit_d;
    logic          rst_q, rst_d;
    logic          pwr_q, pwr_d;
    logic          data_q, data_d;
    logic          pend_q, pend_d;
    logic          irq_en_q, irq_en_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;

    logic          busy;
    logic          tick;
    logic          ctrl_wr;
    logic          ctrl_rd;
    logic          ovd_rd;
    slot_timing_t  tim;
    logic          unused_wdata;

    assign busy    = (state_q != ST_IDLE);
    assign ctrl_wr = avs.avalon_write && (avs.avalon_address == ADDR_CTRL);
    assign ctrl_rd = avs.avalon_read  && (avs.avalon_address == ADDR_CTRL);

    // Prescaler sits at zero between cycles so every slot starts on a clean tick grid
    onewire_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!busy),
        .tick  (tick)
    );

`ifdef ONEWIRE_OVERDRIVE_EN
    logic ovd_q, ovd_d;

    always_comb begin
        ovd_d = ovd_q;
        if (ctrl_wr && !busy) begin
            ovd_d = avs.avalon_writedata[CTRL_OVD];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovd_q <= 1'b0;
        end else begin
            ovd_q <= ovd_d;
        end
    end

    assign ovd_rd = ovd_q;
    assign tim    = ovd_q ? ovd_timing(rst_q, wbit_q) : std_timing(rst_q, wbit_q);
    assign unused_wdata = ^avs.avalon_writedata[31:4];
`else
    assign ovd_rd = 1'b0;
    assign tim    = std_timing(rst_q, wbit_q);
    assign unused_wdata = ^{avs.avalon_writedata[31:4], avs.avalon_writedata[CTRL_OVD]};
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cnt_nxt  = cnt_q + CW'(1);
        wbit_d   = wbit_q;
        rst_d    = rst_q;
        pwr_d    = pwr_q;
        data_d   = data_q;
        pend_d   = pend_q;
        irq_en_d = irq_en_q;
        sync1_d  = owr_i;
        sync2_d  = sync1_q;

        if (avs.avalon_write && (avs.avalon_address == ADDR_IRQ_EN)) begin
            irq_en_d = avs.avalon_writedata[0];
        end

        // Clear first so a completion on the same edge overrides it
        if (ctrl_rd) begin
            pend_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (ctrl_wr) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    wbit_d  = avs.avalon_writedata[CTRL_DATA];
                    rst_d   = avs.avalon_writedata[CTRL_RST];
                    pwr_d   = avs.avalon_writedata[CTRL_PWR];
                end
            end
            ST_LOW, ST_REL: begin
                if (tick) begin
                    cnt_d = cnt_nxt;
                    // Write-0 samples while still driving low, so sampling is not tied to REL
                    if (cnt_nxt == CW'(tim.t_smp)) begin
                        data_d = rst_q ? ~sync2_q : sync2_q;
                    end
                    if ((state_q == ST_LOW) && (cnt_nxt == CW'(tim.t_low))) begin
                        state_d = ST_REL;
                    end
                    if ((state_q == ST_REL) && (cnt_nxt == CW'(tim.t_end))) begin
                        state_d = ST_IDLE;
                        pend_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wbit_q   <= 1'b0;
            rst_q    <= 1'b0;
            pwr_q    <= 1'b0;
            data_q   <= 1'b0;
            pend_q   <= 1'b0;
            irq_en_q <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wbit_q   <= wbit_d;
            rst_q    <= rst_d;
            pwr_q    <= pwr_d;
            data_q   <= data_d;
            pend_q   <= pend_d;
            irq_en_q <= irq_en_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
        end
    end

    // Strong pullup only between cycles, so it never fights owr_e
    assign owr_e = (state_q == ST_LOW);
    assign owr_p = pwr_q && (state_q == ST_IDLE);

    assign avs.avalon_interrupt = pend_q && irq_en_q;

    always_comb begin
        if (avs.avalon_address == ADDR_CTRL) begin
            avs.avalon_readdata = {26'd0, pend_q, busy, ovd_rd, pwr_q, 1'b0, data_q};
        end else begin
            avs.avalon_readdata = {31'd0, irq_en_q};
        end
    end

endmodule

// File: tb/tb_onewire_master.sv
module tb_onewire_master;
    localparam int DIV = 33;

    logic clk;
    logic rst_n;
    logic owr_e;
    logic owr_p;
    logic owr_i;

    onewire_if bus();

    onewire_master #(.DIV(DIV), .CW(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .avs   (bus),
        .owr_e (owr_e),
        .owr_p (owr_p),
        .owr_i (owr_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Device model: 0 = silent, 1 = presence pulse 30..150 us after release,
    // 2 = holds bus low until 30 us after the master starts the slot
    int   dev_mode = 0;
    int   rise_cnt = 1000000;
    int   fall_cnt = 1000000;
    logic owr_e_d  = 1'b0;
    logic dev_pull;

    always @(posedge clk) begin
        owr_e_d <= owr_e;
        if (owr_e && !owr_e_d) rise_cnt <= 0;
        else if (rise_cnt < 1000000) rise_cnt <= rise_cnt + 1;
        if (!owr_e && owr_e_d) fall_cnt <= 0;
        else if (fall_cnt < 1000000) fall_cnt <= fall_cnt + 1;
    end

    assign dev_pull = ((dev_mode == 1) && !owr_e && (fall_cnt >= 30*DIV) && (fall_cnt < 150*DIV))
                   || ((dev_mode == 2) && (rise_cnt < 30*DIV));
    assign owr_i = owr_p ? 1'b1 : (owr_e ? 1'b0 : !dev_pull);

    task automatic bus_write(input logic a, input logic [31:0] d);
        @(negedge clk);
        bus.avalon_address   = a;
        bus.avalon_writedata = d;
        bus.avalon_write     = 1'b1;
        @(negedge clk);
        bus.avalon_write     = 1'b0;
    endtask

    task automatic bus_read(input logic a, output logic [31:0] d);
        @(negedge clk);
        bus.avalon_address = a;
        bus.avalon_read    = 1'b1;
        #1 d = bus.avalon_readdata;
        @(negedge clk);
        bus.avalon_read    = 1'b0;
    endtask

    // Starts a cycle and measures it until the interrupt rises (IRQ_EN must be 1).
    // inj_a/inj_b: sample indices after which a CTRL write of inj_dat is issued.
    task automatic run_cycle(input logic [3:0] ctrl, input int inj_a, input int inj_b,
                             input logic [3:0] inj_dat, output int e_clks, output int p_clks,
                             output int done_at, output logic p_end);
        e_clks  = 0;
        p_clks  = 0;
        done_at = -1;
        p_end   = 1'b0;
        @(negedge clk);
        bus.avalon_address   = 1'b0;
        bus.avalon_writedata = {28'd0, ctrl};
        bus.avalon_write     = 1'b1;
        for (int i = 1; i <= 40000; i++) begin
            @(negedge clk);
            bus.avalon_write = 1'b0;
            if (bus.avalon_interrupt) begin
                done_at = i - 1;
                p_end   = owr_p;
                break;
            end
            if (owr_e) e_clks++;
            if (owr_p) p_clks++;
            if (i == inj_a || i == inj_b) begin
                bus.avalon_writedata = {28'd0, inj_dat};
                bus.avalon_write     = 1'b1;
            end
        end
        bus.avalon_write = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        n_cmp++; if (owr_e !== 1'b0) begin n_err++; $display("FAIL reset_owr_e: got %b expected 0", owr_e); end
        n_cmp++; if (owr_p !== 1'b0) begin n_err++; $display("FAIL reset_owr_p: got %b expected 0", owr_p); end
        n_cmp++; if (bus.avalon_interrupt !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", bus.avalon_interrupt); end
        rst_n = 1'b1;
        bus_read(1'b0, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h expected 00000000", rd); end
        bus_read(1'b1, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_irq_en: got %h expected 00000000", rd); end
    endtask

    task automatic test_reset_presence();
        int e, p, d; logic pe; logic [31:0] rd;
        bus_write(1'b1, 32'h1);
        dev_mode = 1;
        run_cycle(4'b0010, -1, -1, 4'h0, e, p, d, pe);
        n_cmp++; if (e !== 15840) begin n_err++; $display("FAIL presence_low_clks: got %0d expected 15840", e); end
        n_cmp++; if (d !== 31680) begin n_err++; $display("FAIL presence_len: got %0d expected 31680", d); end
        bus_read(1'b0, rd);
        n_cmp++; if (rd !== 32'h21) begin n_err++; $display("FAIL presence_status: got %h expected 00000021", rd); end
        n_cmp++; if (bus.avalon_interrupt !== 1'b0) begin n_err++; $display("FAIL presence_irq_clr: got %b expected 0", bus.avalon_interrupt); end
        dev_mode = 0;
    endtask

    task automatic test_reset_no_device();
        int irq_seen; logic [31:0] rd;
        irq_seen = 0;
        dev_mode = 0;
        bus_write(1'b1, 32'h0);
        bus_write(1'b0, 32'h2);
        for (int i = 0; i < 31690; i++) begin
            @(negedge clk);
            if (bus.avalon_interrupt) irq_seen++;
        end
        n_cmp++; if (irq_seen !== 0) begin n_err++; $display("FAIL nodev_irq_masked: got %0d expected 0", irq_seen); end
        bus_write(1'b1, 32'h1);
        n_cmp++; if (bus.avalon_interrupt !== 1'b1) begin n_err++; $display("FAIL nodev_irq_on: got %b expected 1", bus.avalon_interrupt); end
        bus_read(1'b0, rd);
        n_cmp++; if (rd !== 32'h20) begin n_err++; $display("FAIL nodev_status: got %h expected 00000020", rd); end
        n_cmp++; if (bus.avalon_interrupt !== 1'b0) begin n_err++; $display("FAIL nodev_irq_clr: got %b expected 0", bus.avalon_interrupt); end
    endtask

    task automatic test_write_slots();
        int e, p, d; logic pe; logic [31:0] rd;
        run_cycle(4'b0000, -1, -1, 4'h0, e, p, d, pe);
        n_cmp++; if (e !== 1980) begin n_err++; $display("FAIL w0_low_clks: got %0d expected 1980", e); end
        n_cmp++; if (d !== 2310) begin n_err++; $display("FAIL w0_len: got %0d expected 2310", d); end
        n_cmp++; if (p !== 0) begin n_err++; $display("FAIL w0_pullup: got %0d expected 0", p); end
        bus_read(1'b0, rd);
        n_cmp++; if (rd !== 32'h20) begin n_err++; $display("FAIL w0_status: got %h expected 00000020", rd); end
        run_cycle(4'b0001, -1, -1, 4'h0, e, p, d, pe);
        n_cmp++; if (e !== 198) begin n_err++; $display("FAIL w1_low_clks: got %0d expected 198", e); end
        n_cmp++; if (d !== 2310) begin n_err++; $display("FAIL w1_len: got %0d expected 2310", d); end
        n_cmp++; if (p !== 0) begin n_err++; $display("FAIL w1_pullup: got %0d expected 0", p); end
        bus_read(1'b0, rd);
        n_cmp++; if (rd !== 32'h21) begin n_err++; $display("FAIL w1_status: got %h expected 00000021", rd); end
    endtask

    task automatic test_read_slot();
        int e, p, d; logic pe; logic [31:0] rd;
        dev_mode = 2;
        run_cycle(4'b0001, -1, -1, 4'h0, e, p, d, pe);
        dev_mode = 0;
        n_cmp++; if (d !== 2310) begin n_err++; $display("FAIL rd_len: got %0d expected 2310", d); end
        bus_read(1'b0, rd);
        n_cmp++; if (rd !== 32'h20) begin n_err++; $display("FAIL rd_held_low: got %h expected 00000020", rd); end
    endtask

    task automatic test_pwr_and_busy_writes();
        int e, p, d; logic pe; logic [31:0] rd;
        // Reset-cycle writes mid-slot and on the completion edge must both be dropped
        run_cycle(4'b0101, 500, 2310, 4'b0010, e, p, d, pe);
        n_cmp++; if (e !== 198) begin n_err++; $display("FAIL pwr_low_clks: got %0d expected 198", e); end
        n_cmp++; if (d !== 2310) begin n_err++; $display("FAIL pwr_len: got %0d expected 2310", d); end
        n_cmp++; if (p !== 0) begin n_err++; $display("FAIL pwr_pullup_during: got %0d expected 0", p); end
        n_cmp++; if (pe !== 1'b1) begin n_err++; $display("FAIL pwr_pullup_after: got %b expected 1", pe); end
        n_cmp++; if (owr_e !== 1'b0) begin n_err++; $display("FAIL edge_write_ignored: got %b expected 0", owr_e); end
        bus_read(1'b0, rd);
        n_cmp++; if (rd !== 32'h25) begin n_err++; $display("FAIL pwr_status: got %h expected 00000025", rd); end
    endtask

    task automatic test_overdrive();
        int e, p, d; logic pe; logic [31:0] rd;
`ifdef ONEWIRE_OVERDRIVE_EN
        run_cycle(4'b1010, -1, -1, 4'h0, e, p, d, pe);
        n_cmp++; if (e !== 1584) begin n_err++; $display("FAIL ovd_low_clks: got %0d expected 1584", e); end
        n_cmp++; if (d !== 3168) begin n_err++; $display("FAIL ovd_len: got %0d expected 3168", d); end
        bus_read(1'b0, rd);
        n_cmp++; if (rd !== 32'h28) begin n_err++; $display("FAIL ovd_status: got %h expected 00000028", rd); end
`else
        run_cycle(4'b1001, -1, -1, 4'h0, e, p, d, pe);
        n_cmp++; if (e !== 198) begin n_err++; $display("FAIL ovd_off_low_clks: got %0d expected 198", e); end
        n_cmp++; if (d !== 2310) begin n_err++; $display("FAIL ovd_off_len: got %0d expected 2310", d); end
        bus_read(1'b0, rd);
        n_cmp++; if (rd !== 32'h21) begin n_err++; $display("FAIL ovd_off_status: got %h expected 00000021", rd); end
`endif
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        bus_write(1'b0, 32'h6);
        repeat (6600) @(negedge clk);
        n_cmp++; if (owr_e !== 1'b1) begin n_err++; $display("FAIL abort_pre_low: got %b expected 1", owr_e); end
        rst_n = 1'b0;
        @(negedge clk);
        bus.avalon_address = 1'b0;
        #1;
        n_cmp++; if (owr_e !== 1'b0) begin n_err++; $display("FAIL abort_owr_e: got %b expected 0", owr_e); end
        n_cmp++; if (owr_p !== 1'b0) begin n_err++; $display("FAIL abort_owr_p: got %b expected 0", owr_p); end
        n_cmp++; if (bus.avalon_readdata !== 32'h0) begin n_err++; $display("FAIL abort_status: got %h expected 00000000", bus.avalon_readdata); end
        rst_n = 1'b1;
        bus_read(1'b1, rd);
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL abort_irq_en: got %h expected 00000000", rd); end
    endtask

    initial begin
        rst_n                = 1'b0;
        bus.avalon_address   = 1'b0;
        bus.avalon_read      = 1'b0;
        bus.avalon_write     = 1'b0;
        bus.avalon_writedata = 32'h0;
        test_reset();
        test_reset_presence();
        test_reset_no_device();
        test_write_slots();
        test_read_slot();
        test_pwr_and_busy_writes();
        test_overdrive();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
